// File: rtl/program_memory_pkg.sv
// Shared types and default widths for the run-time loadable program memory.
// The width constants match the core's fetch port and the assembler's image format.
package program_memory_pkg;

  localparam int PM_DATA_WIDTH = 8;
  localparam int PM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } pm_state_t;

endpackage

// File: rtl/program_memory_if.sv
// Core fetch port plus host load stream for the program memory.
// master = core/loader side, slave = memory side.
interface program_memory_if
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = PM_DATA_WIDTH,
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  ready;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic                  load_error;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output address, load_start, load_valid, load_data, load_last,
    input  dataout, ready, load_ready, load_done, load_error, checksum
  );

  modport slave (
    input  address, load_start, load_valid, load_data, load_last,
    output dataout, ready, load_ready, load_done, load_error, checksum
  );

endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered read.
// The write source is either zero (clear sweep) or a load beat; the read
// register returns zero when reads are disabled so stale words never leak out.
module sync_ram
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = PM_DATA_WIDTH,
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  clear_we,
  input  logic                  load_we,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;

  // Write mux: a load beat carries data, a clear write carries zero.
  always_comb begin
    we    = clear_we | load_we;
    wdata = load_we ? load_data : '0;
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read port, forced to zero outside of fetch service.
  always_ff @(posedge clk) begin
    if (reset || !rd_en) q <= '0;
    else                 q <= mem[addr];
  end

endmodule

// File: rtl/program_memory.sv
// Run-time loadable instruction memory: FSM, write pointer, checksum, flags.
//
// state | meaning
// CLEAR | zero-fill mem[ptr..DEPTH-1], one word per cycle
// RUN   | serve core fetches, wait for load_start
// LOAD  | accept program beats into mem[ptr], accumulate checksum
module program_memory
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = PM_DATA_WIDTH,
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  program_memory_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

  pm_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] checksum, checksum_nxt;
  logic                  load_error, error_nxt;
  logic                  load_done, done_nxt;
  logic                  from_load, from_load_nxt;
  logic                  clear_we, load_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] ram_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      checksum   <= '0;
      load_error <= 1'b0;
      load_done  <= 1'b0;
      from_load  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      checksum   <= checksum_nxt;
      load_error <= error_nxt;
      load_done  <= done_nxt;
      from_load  <= from_load_nxt;
    end
  end

  // Next-state, pointer, checksum and write-enable decode.
  // from_load remembers that a CLEAR is a tail fill so load_done fires at its end.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    checksum_nxt  = checksum;
    error_nxt     = load_error;
    done_nxt      = 1'b0;
    from_load_nxt = from_load;
    clear_we      = 1'b0;
    load_we       = 1'b0;
    case (state)
      CLEAR: begin
        clear_we = !reset;
        if (ptr == PTR_LAST) begin
          state_nxt     = RUN;
          done_nxt      = from_load;
          from_load_nxt = 1'b0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_nxt    = LOAD;
          ptr_nxt      = '0;
          checksum_nxt = '0;
          error_nxt    = 1'b0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          load_we      = !reset;
          checksum_nxt = checksum + bus.load_data;
          if (ptr == PTR_LAST) begin
            // Last word of the array ends the load whether or not it was marked last.
            state_nxt = RUN;
            done_nxt  = 1'b1;
            if (!bus.load_last) error_nxt = 1'b1;
          end else if (bus.load_last) begin
            state_nxt     = CLEAR;
            ptr_nxt       = ptr + 1'b1;
            from_load_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // RAM port is owned by the core in RUN and by the pointer otherwise.
  always_comb begin
    ram_addr = (state == RUN) ? bus.address : ptr;
    rd_en    = (state == RUN) && !reset;
  end

  sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .addr      (ram_addr),
    .clear_we  (clear_we),
    .load_we   (load_we),
    .load_data (bus.load_data),
    .rd_en     (rd_en),
    .q         (ram_q)
  );

  assign bus.ready      = (state == RUN);
  assign bus.load_ready = (state == LOAD);
  assign bus.load_done  = load_done;
  assign bus.load_error = load_error;
  assign bus.checksum   = checksum;
  assign bus.dataout    = bus.ready ? ram_q : '0;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: reset clear, loads, reload, overflow,
// reset mid-load and a gappy load with stray load_start.
module tb_program_memory;
  import program_memory_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [7:0] prog [0:255];

  program_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  program_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.address = a;
    step();
    check(tag, bus.dataout, exp);
  endtask

  task automatic wait_ready(output int cyc, output logic saw_done);
    cyc = 0;
    saw_done = 1'b0;
    while (!bus.ready && cyc < 400) begin
      step();
      cyc++;
      if (bus.load_done) saw_done = 1'b1;
    end
  endtask

  task automatic do_load(input int n, input bit gaps, output int clr);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    check("load_ready_after_start", bus.load_ready, 1);
    check("ready_low_in_load", bus.ready, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.load_valid = 1'b0;
          bus.load_start = 1'b1;
          step();
        end
        bus.load_start = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_last  = (i == n - 1);
      step();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    clr = 0;
    while (!bus.load_done && clr < 400) begin
      step();
      clr++;
    end
    check("load_done_seen", bus.load_done, 1);
    check("ready_with_done", bus.ready, 1);
  endtask

  task automatic build_prog22();
    for (int i = 0; i < 10; i++) begin
      prog[2*i]   = 8'h30 + 8'(i);
      prog[2*i+1] = 8'h86;
    end
    prog[20] = 8'h00;
    prog[21] = 8'hC4;
  endtask

  initial begin
    int   cyc;
    int   clr;
    logic sd;

    reset          = 1'b1;
    bus.address    = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    repeat (3) step();
    check("rst_ready", bus.ready, 0);
    check("rst_dataout", bus.dataout, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_load_error", bus.load_error, 0);
    check("rst_checksum", bus.checksum, 0);

    reset = 1'b0;
    wait_ready(cyc, sd);
    check("post_reset_cycles", cyc, 256);
    check("post_reset_no_done", sd, 0);
    read_chk(8'h00, 8'h00, "init_rd_00");
    read_chk(8'h7F, 8'h00, "init_rd_7f");
    read_chk(8'hFF, 8'h00, "init_rd_ff");

    // 22-byte program, last beat at 0x15 -> 234 tail-fill cycles.
    build_prog22();
    do_load(22, 1'b0, clr);
    check("p22_clear_cycles", clr, 234);
    check("p22_checksum", bus.checksum, 8'h0D);
    step();
    check("p22_done_one_cycle", bus.load_done, 0);
    read_chk(8'h15, 8'hC4, "p22_rd_15");
    read_chk(8'h16, 8'h00, "p22_rd_16");
    read_chk(8'h00, 8'h30, "p22_rd_00");
    read_chk(8'h13, 8'h86, "p22_rd_13");
    check("p22_checksum_stable", bus.checksum, 8'h0D);

    // Reload a 2-byte program over it; the old tail must be gone.
    prog[0] = 8'h55;
    prog[1] = 8'hAA;
    do_load(2, 1'b0, clr);
    check("p2_clear_cycles", clr, 254);
    check("p2_checksum", bus.checksum, 8'hFF);
    read_chk(8'h00, 8'h55, "p2_rd_00");
    read_chk(8'h01, 8'hAA, "p2_rd_01");
    for (int a = 2; a <= 8'h15; a++) read_chk(8'(a), 8'h00, "p2_rd_tail");

    // Overflow: 257 beats of 0x01 with no load_last.
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h01;
    bus.load_last  = 1'b0;
    for (int i = 0; i < 257; i++) begin
      if (i == 0)   check("ovf_ready_first", bus.load_ready, 1);
      if (i == 255) check("ovf_ready_last", bus.load_ready, 1);
      if (i == 256) begin
        check("ovf_beat257_load_ready", bus.load_ready, 0);
        check("ovf_done", bus.load_done, 1);
        check("ovf_ready", bus.ready, 1);
        check("ovf_error", bus.load_error, 1);
      end
      step();
    end
    bus.load_valid = 1'b0;
    check("ovf_done_pulse", bus.load_done, 0);
    check("ovf_checksum", bus.checksum, 8'h00);
    check("ovf_error_sticky", bus.load_error, 1);
    read_chk(8'hFF, 8'h01, "ovf_rd_ff");
    read_chk(8'h10, 8'h01, "ovf_rd_10");

    // Next load_start clears the error; abort with reset after 10 beats.
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    check("err_cleared", bus.load_error, 0);
    check("midload_load_ready", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h11;
    repeat (10) step();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    step();
    step();
    check("midrst_ready", bus.ready, 0);
    check("midrst_load_ready", bus.load_ready, 0);
    check("midrst_checksum", bus.checksum, 0);
    reset = 1'b0;
    wait_ready(cyc, sd);
    check("midrst_cycles", cyc, 256);
    check("midrst_no_done", sd, 0);
    check("midrst_checksum_run", bus.checksum, 0);
    check("midrst_error", bus.load_error, 0);
    read_chk(8'h00, 8'h00, "midrst_rd_00");
    read_chk(8'h05, 8'h00, "midrst_rd_05");
    read_chk(8'h09, 8'h00, "midrst_rd_09");
    read_chk(8'hFF, 8'h00, "midrst_rd_ff");

    // Gappy load with stray load_start must match a gap-free load.
    build_prog22();
    do_load(22, 1'b1, clr);
    check("gap_clear_cycles", clr, 234);
    check("gap_checksum", bus.checksum, 8'h0D);
    for (int a = 0; a <= 8'h16; a++)
      read_chk(8'(a), (a < 22) ? prog[a] : 8'h00, "gap_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
